// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file: NUM_REGS word registers with byte strobes,
// optional read-only registers sourced from host inputs, and per-register write pulses.
module axi_lite_regfile #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           AWVALID,
   output logic                           AWREADY,
   input  logic [ADDR_WIDTH-1:0]          AWADDR,
   input  logic                           WVALID,
   output logic                           WREADY,
   input  logic [DATA_WIDTH-1:0]          WDATA,
   input  logic [DATA_WIDTH/8-1:0]        WSTRB,
   output logic                           BVALID,
   input  logic                           BREADY,
   output logic [1:0]                     BRESP,
   input  logic                           ARVALID,
   output logic                           ARREADY,
   input  logic [ADDR_WIDTH-1:0]          ARADDR,
   output logic                           RVALID,
   input  logic                           RREADY,
   output logic [DATA_WIDTH-1:0]          RDATA,
   output logic [1:0]                     RRESP,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_i,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFFS   = $clog2(STRB_W);
   localparam int IDX_W  = ADDR_WIDTH - OFFS;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // One-hot register select; all zeros when the word index is out of range.
   function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      logic [IDX_W-1:0] idx;
      decode = '0;
      idx    = addr[ADDR_WIDTH-1:OFFS];
      for (int i = 0; i < NUM_REGS; i++) begin
         decode[i] = (int'(idx) == i);
      end
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_val,
                                                   input logic [DATA_WIDTH-1:0] new_val,
                                                   input logic [STRB_W-1:0]     strb);
      merge = old_val;
      for (int k = 0; k < STRB_W; k++) begin
         if (strb[k]) merge[8*k +: 8] = new_val[8*k +: 8];
      end
   endfunction

   logic                                     aw_held_q, aw_held_d;
   logic [ADDR_WIDTH-1:0]                    aw_addr_q, aw_addr_d;
   logic                                     w_held_q, w_held_d;
   logic [DATA_WIDTH-1:0]                    w_data_q, w_data_d;
   logic [STRB_W-1:0]                        w_strb_q, w_strb_d;
   logic                                     bvalid_q, bvalid_d;
   logic [1:0]                               bresp_q, bresp_d;
   logic [NUM_REGS-1:0]                      wr_pulse_q, wr_pulse_d;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]      regs_q, regs_d;
   logic                                     rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]                    rdata_q, rdata_d;
   logic [1:0]                               rresp_q, rresp_d;

   logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
   logic [ADDR_WIDTH-1:0] cur_awaddr;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic [STRB_W-1:0]     cur_wstrb;
   logic [NUM_REGS-1:0]   wr_sel, rd_sel;
   logic [DATA_WIDTH-1:0] rd_val;

   // Every channel transfers on a rising edge where VALID and READY are both high;
   // a source keeps VALID and its payload steady until that edge, READY never waits on VALID.
   assign AWREADY    = !aw_held_q && !bvalid_q;
   assign WREADY     = !w_held_q && !bvalid_q;
   assign ARREADY    = !rvalid_q;
   assign BVALID     = bvalid_q;
   assign BRESP      = bresp_q;
   assign RVALID     = rvalid_q;
   assign RDATA      = rdata_q;
   assign RRESP      = rresp_q;
   assign wr_pulse_o = wr_pulse_q;

   always_comb begin
      aw_hs      = AWVALID && AWREADY;
      w_hs       = WVALID && WREADY;
      ar_hs      = ARVALID && ARREADY;
      cur_awaddr = aw_held_q ? aw_addr_q : AWADDR;
      cur_wdata  = w_held_q ? w_data_q : WDATA;
      cur_wstrb  = w_held_q ? w_strb_q : WSTRB;
      commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs);
      wr_sel     = decode(cur_awaddr);
      wr_ok      = |(wr_sel & ~RO_MASK);
      rd_sel     = decode(ARADDR);
   end

   // Read mux samples the pre-commit register contents, so a same-edge read sees the old value.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_sel[i]) rd_val = RO_MASK[i] ? ro_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
   end

   always_comb begin
      regs_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? ro_i[i*DATA_WIDTH +: DATA_WIDTH]
                                                         : regs_q[i];
      end
   end

   always_comb begin
      aw_held_d  = aw_held_q;
      aw_addr_d  = aw_addr_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = AWADDR;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = WDATA;
         w_strb_d = WSTRB;
      end
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (wr_ok) begin
            wr_pulse_d = wr_sel;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (wr_sel[i] && !RO_MASK[i]) regs_d[i] = merge(regs_q[i], cur_wdata, cur_wstrb);
            end
         end
      end else if (bvalid_q && BREADY) begin
         bvalid_d = 1'b0;
      end
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = (|rd_sel) ? rd_val : '0;
         rresp_d  = (|rd_sel) ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held_q  <= 1'b0;
         aw_addr_q  <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         regs_q     <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         aw_held_q  <= aw_held_d;
         aw_addr_q  <= aw_addr_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         regs_q     <= regs_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: a reference register model feeds expected
// B/R responses into queues that are popped when the DUT answers.
module tb_axi_lite_regfile;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NR = 16;
   localparam int SW = DW / 8;
   localparam logic [NR-1:0] RO = 16'h8000;

   logic              clk, rst_n;
   logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic              ARVALID, ARREADY, RVALID, RREADY;
   logic [AW-1:0]     AWADDR, ARADDR;
   logic [DW-1:0]     WDATA, RDATA;
   logic [SW-1:0]     WSTRB;
   logic [1:0]        BRESP, RRESP;
   logic [NR*DW-1:0]  regs_o, ro_i;
   logic [NR-1:0]     wr_pulse_o;

   int                tests = 0;
   int                fails = 0;
   logic [1:0]        b_exp_q[$];
   logic [DW+1:0]     r_exp_q[$];
   logic [DW-1:0]     model[NR];
   logic [DW+1:0]     r_exp;
   logic [1:0]        b_exp;

   axi_lite_regfile #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
      .regs_o(regs_o), .ro_i(ro_i), .wr_pulse_o(wr_pulse_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [SW-1:0] s);
      logic [DW-1:0] r;
      r = o;
      for (int k = 0; k < SW; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
      return r;
   endfunction

   function automatic logic [NR*DW-1:0] exp_regs();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? ro_i[i*DW +: DW] : model[i];
      return v;
   endfunction

   function automatic logic [DW+1:0] read_exp(input logic [AW-1:0] addr);
      int idx;
      idx = int'(addr) >> 2;
      if (idx >= NR) return {2'b10, {DW{1'b0}}};
      if (RO[idx]) return {2'b00, ro_i[idx*DW +: DW]};
      return {2'b00, model[idx]};
   endfunction

   // driver tasks
   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb);
      int idx;
      logic ok;
      logic [NR-1:0] exp_pulse;
      idx = int'(addr) >> 2;
      ok = 1'b0;
      if (idx < NR) ok = !RO[idx];
      exp_pulse = '0;
      if (ok) begin
         exp_pulse[idx] = 1'b1;
         model[idx] = merge(model[idx], data, strb);
      end
      b_exp_q.push_back(ok ? 2'b00 : 2'b10);
      AWVALID = 1'b1; AWADDR = addr; WVALID = 1'b1; WDATA = data; WSTRB = strb; BREADY = 1'b1;
      check("wr_awready", AWREADY, 1'b1);
      check("wr_wready", WREADY, 1'b1);
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      check("wr_bvalid_latency", BVALID, 1'b1);
      check("wr_bresp", BRESP, b_exp_q.pop_front());
      check("wr_pulse", wr_pulse_o, exp_pulse);
      check("wr_regs_o", regs_o, exp_regs());
      tick();
      check("wr_bvalid_clear", BVALID, 1'b0);
      check("wr_pulse_clear", wr_pulse_o, '0);
   endtask

   task automatic do_read(input logic [AW-1:0] addr);
      logic [DW+1:0] e;
      r_exp_q.push_back(read_exp(addr));
      ARVALID = 1'b1; ARADDR = addr; RREADY = 1'b1;
      check("rd_arready", ARREADY, 1'b1);
      tick();
      ARVALID = 1'b0;
      check("rd_rvalid_latency", RVALID, 1'b1);
      e = r_exp_q.pop_front();
      check("rd_rdata", RDATA, e[DW-1:0]);
      check("rd_rresp", RRESP, e[DW+1:DW]);
      tick();
      check("rd_rvalid_clear", RVALID, 1'b0);
   endtask

   // AW and W arrive three cycles apart; the later one triggers the commit.
   task automatic split_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic aw_first);
      int idx;
      idx = int'(addr) >> 2;
      b_exp_q.push_back(2'b00);
      BREADY = 1'b1;
      if (aw_first) begin AWVALID = 1'b1; AWADDR = addr; end
      else begin WVALID = 1'b1; WDATA = data; WSTRB = '1; end
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         check(aw_first ? "split_awready_held" : "split_wready_held",
               aw_first ? AWREADY : WREADY, 1'b0);
         check("split_no_bvalid", BVALID, 1'b0);
         tick();
      end
      if (aw_first) begin WVALID = 1'b1; WDATA = data; WSTRB = '1; end
      else begin AWVALID = 1'b1; AWADDR = addr; end
      check(aw_first ? "split_awready_c3" : "split_wready_c3", aw_first ? AWREADY : WREADY, 1'b0);
      check(aw_first ? "split_wready_c3b" : "split_awready_c3b", aw_first ? WREADY : AWREADY, 1'b1);
      check("split_no_bvalid_c3", BVALID, 1'b0);
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      model[idx] = data;
      check("split_bvalid", BVALID, 1'b1);
      check("split_bresp", BRESP, b_exp_q.pop_front());
      check("split_pulse", wr_pulse_o, NR'(1) << idx);
      check("split_slice", regs_o[idx*DW +: DW], data);
      tick();
      check("split_bvalid_clear", BVALID, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b0;
      ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
      for (int i = 0; i < NR; i++) begin
         ro_i[i*DW +: DW] = $urandom;
         model[i] = '0;
      end
      ro_i[15*DW +: DW] = 32'hCAFE0001;
      @(negedge clk);
      tick();

      // reset values
      check("rst_awready", AWREADY, 1'b1);
      check("rst_wready", WREADY, 1'b1);
      check("rst_arready", ARREADY, 1'b1);
      check("rst_bvalid", BVALID, 1'b0);
      check("rst_bresp", BRESP, 2'b00);
      check("rst_rvalid", RVALID, 1'b0);
      check("rst_rdata", RDATA, '0);
      check("rst_rresp", RRESP, 2'b00);
      check("rst_pulse", wr_pulse_o, '0);
      check("rst_regs_o", regs_o, exp_regs());
      rst_n = 1'b1;
      tick();

      do_read(8'h04);

      // full write then strobed partial write
      do_write(8'h08, 32'hDEADBEEF, 4'hF);
      do_write(8'h08, 32'h11223344, 4'h5);
      check("strobe_model", model[2], 32'hDE22BE44);
      do_read(8'h08);

      split_write(8'h10, 32'h00000055, 1'b1);
      split_write(8'h14, 32'h00000055, 1'b0);

      // read-only and out-of-range targets
      do_write(8'h3C, 32'h12345678, 4'hF);
      do_read(8'h3C);
      do_write(8'h40, 32'h87654321, 4'hF);
      do_read(8'h40);

      // B backpressure with a second AW waiting
      BREADY = 1'b0;
      model[3] = 32'h0BADF00D;
      AWVALID = 1'b1; AWADDR = 8'h0C; WVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
      tick();
      check("bp_pulse", wr_pulse_o, NR'(1) << 3);
      AWADDR = 8'h20; WVALID = 1'b0;
      b_exp = 2'b00;
      for (int k = 0; k < 5; k++) begin
         check("bp_bvalid_hold", BVALID, 1'b1);
         check("bp_bresp_hold", BRESP, b_exp);
         check("bp_awready", AWREADY, 1'b0);
         check("bp_wready", WREADY, 1'b0);
         tick();
      end
      BREADY = 1'b1;
      tick();
      check("bp_bvalid_done", BVALID, 1'b0);
      check("bp_awready_back", AWREADY, 1'b1);
      check("bp_aw_not_taken", regs_o[8*DW +: DW], model[8]);
      WVALID = 1'b1; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF;
      b_exp_q.push_back(2'b00);
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      model[8] = 32'h5A5A5A5A;
      check("bp2_bvalid", BVALID, 1'b1);
      check("bp2_bresp", BRESP, b_exp_q.pop_front());
      check("bp2_regs_o", regs_o, exp_regs());
      tick();

      // R backpressure with a second AR waiting
      RREADY = 1'b0;
      ARVALID = 1'b1; ARADDR = 8'h08;
      r_exp_q.push_back(read_exp(8'h08));
      tick();
      ARADDR = 8'h0C;
      r_exp = r_exp_q.pop_front();
      for (int k = 0; k < 4; k++) begin
         check("rbp_rvalid", RVALID, 1'b1);
         check("rbp_rdata", RDATA, r_exp[DW-1:0]);
         check("rbp_arready", ARREADY, 1'b0);
         tick();
      end
      RREADY = 1'b1;
      tick();
      check("rbp_rvalid_done", RVALID, 1'b0);
      check("rbp_arready_back", ARREADY, 1'b1);
      r_exp_q.push_back(read_exp(8'h0C));
      tick();
      ARVALID = 1'b0;
      r_exp = r_exp_q.pop_front();
      check("rbp2_rvalid", RVALID, 1'b1);
      check("rbp2_rdata", RDATA, r_exp[DW-1:0]);
      tick();

      // random strobed writes with read-back
      for (int n = 0; n < 6; n++) begin
         logic [AW-1:0] a;
         a = AW'($urandom_range(0, 14) * 4);
         do_write(a, $urandom, SW'($urandom_range(0, 15)));
         do_read(a);
      end

      // reset with AW held and a read response pending
      AWVALID = 1'b1; AWADDR = 8'h18; RREADY = 1'b0; ARVALID = 1'b1; ARADDR = 8'h08;
      tick();
      AWVALID = 1'b0; ARVALID = 1'b0;
      check("mid_aw_held", AWREADY, 1'b0);
      check("mid_rvalid", RVALID, 1'b1);
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = '0;
      #1;
      check("mid_rst_bvalid", BVALID, 1'b0);
      check("mid_rst_rvalid", RVALID, 1'b0);
      check("mid_rst_awready", AWREADY, 1'b1);
      check("mid_rst_regs", regs_o, exp_regs());
      tick();
      rst_n = 1'b1;
      tick();
      do_read(8'h08);
      WVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; BREADY = 1'b1;
      tick();
      WVALID = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("lone_w_no_bvalid", BVALID, 1'b0);
         check("lone_w_regs", regs_o, exp_regs());
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

Parametrised AXI-Lite slave register file for the AXI-Lite test environment. Decodes word-aligned addresses into `NUM_REGS` registers of `DATA_WIDTH` bits and applies byte-lane write strobes. Accepts AW and W beats independently and returns OKAY/SLVERR responses. Exposes all register contents to host logic and reads read-only registers from host inputs. It is the DUT behind the interface's `Slave` modport.

## Interface
- `ADDR_WIDTH`, 8: AWADDR/ARADDR width.
- `DATA_WIDTH`, 32: data width; 32 or 64 only.
- `NUM_REGS`, 16: register count; at most 2^(ADDR_WIDTH − log2(DATA_WIDTH/8)).
- `RO_MASK`, 0: NUM_REGS-bit mask; bit i set means register i is read-only.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `AWVALID` in 1, `AWREADY` out 1, `AWADDR` in ADDR_WIDTH: write address channel.
- `WVALID` in 1, `WREADY` out 1, `WDATA` in DATA_WIDTH, `WSTRB` in DATA_WIDTH/8: write data channel.
- `BVALID` out 1, `BREADY` in 1, `BRESP` out 2: write response; 2'b00 OKAY, 2'b10 SLVERR.
- `ARVALID` in 1, `ARREADY` out 1, `ARADDR` in ADDR_WIDTH: read address channel.
- `RVALID` out 1, `RREADY` in 1, `RDATA` out DATA_WIDTH, `RRESP` out 2: read data channel.
- `regs_o` out NUM_REGS*DATA_WIDTH: flat register contents; register i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- `ro_i` in NUM_REGS*DATA_WIDTH: host values for read-only registers; slices of RW registers are ignored.
- `wr_pulse_o` out NUM_REGS: one-cycle pulse per register write commit.

## Operation
- Index = ADDR >> log2(DATA_WIDTH/8); the low address bits are ignored.
- Index ≥ NUM_REGS: decode error.
- Write path:
  - One-entry holders for AW (`aw_held`) and W (`w_held`).
  - `AWREADY = !aw_held && !BVALID`; `WREADY = !w_held && !BVALID`. Both are combinational.
  - Commit edge: the first posedge at which AW is held or handshaking AND W is held or handshaking.
  - At the commit edge, for a valid index that is RW, byte k of the register takes WDATA byte k where WSTRB[k]=1. BRESP=OKAY and `wr_pulse_o[i]` is asserted for one cycle. WSTRB=0 still gives OKAY and a pulse, with no data change.
  - Decode error or RO target: no register change, no pulse, BRESP=SLVERR.
  - The commit edge also sets BVALID and clears both holders.
  - BVALID/BRESP hold until a BREADY handshake. No new AW or W beat is accepted while BVALID=1.
- Read path:
  - `ARREADY = !RVALID`.
  - On an AR handshake, RDATA/RRESP are registered and RVALID is set. They hold until an RREADY handshake.
  - RW register: RDATA = stored value. RO register: RDATA = `ro_i` slice. Both give RRESP=OKAY.
  - Decode error: RDATA=0, RRESP=SLVERR.
- Read and write paths are fully independent.
- A same-edge AR handshake and write commit to the same register returns the pre-write value.

## Timing
- Reset values while `rst_n`=0, applied asynchronously:
  - Zero: all RW registers, `regs_o` RW slices, BVALID, BRESP, RVALID, RRESP, RDATA, `wr_pulse_o`, holders.
  - One: AWREADY, WREADY, ARREADY.
- Write latency: with AW and W handshaking on the same edge N, the register update, BVALID=1 and `wr_pulse_o` are all visible in cycle N+1.
- Split AW/W: commit occurs on the later handshake edge; response follows one cycle after it.
- BREADY high when BVALID rises: B handshake on the next edge. Total write throughput is one write per 2 cycles.
- Read latency: AR handshake at edge N gives RVALID in cycle N+1. Read throughput is one read per 2 cycles with RREADY held high.
- `regs_o` reflects the update in the cycle after commit.
- Reset mid-transaction discards held beats and pending B/R responses. A lone W arriving after reset does not commit.

## Test plan
- Reset, then read 0x04 → RDATA=0x00000000, RRESP=00, RVALID one cycle after AR handshake. All READYs are 1 after reset.
- Write 0x08/0xDEADBEEF/strb 0xF, then 0x08/0x11223344/strb 0x5 → read 0x08 = 0xDE22BE44. BVALID appears 1 cycle after each handshake. `wr_pulse_o[2]` pulses once per write.
- AW 0x10 at cycle 0 with W 0x00000055 at cycle 3 → AWREADY=0 during cycles 1–3, commit at cycle 3, BVALID at cycle 4. Repeat with W first → same result. `regs_o` slice 4 = 0x00000055.
- With RO_MASK=0x8000 and `ro_i` slice 15 = 0xCAFE0001:
  - Write 0x3C → BRESP=10, no pulse.
  - Read 0x3C → 0xCAFE0001, OKAY.
  - Write 0x40 → BRESP=10, no register change.
  - Read 0x40 → RDATA=0, RRESP=10.
- Hold BREADY=0 for 5 cycles → BVALID/BRESP stable, AWREADY=WREADY=0, second AW not accepted until the B handshake. Hold RREADY=0 → RDATA stable and ARREADY=0.
- AW accepted and W pending, then pulse `rst_n` low for 1 cycle → BVALID=0, registers 0. A following lone W → no BVALID.
